// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer
//
// Reads a burst of LEN words from a two-port message SRAM read port, starting at
// BASE_ADDR and wrapping modulo DEPTH, and delivers them on a valid/ready stream.
// SRAM reads are credit limited: issued-but-unpopped reads never exceed FD. This
// guarantees that the FD-entry output buffer cannot overflow.
//
// Ports
//   CLK         clock, rising edge (shared with the SRAM read port)
//   RSTN        synchronous active-low reset
//   START       one-cycle burst request; BASE_ADDR and LEN sampled with it
//   BASE_ADDR   first word address
//   LEN         number of words to read (0..DEPTH)
//   BUSY        burst in progress
//   DONE        one-cycle pulse after the last word is accepted (or after LEN=0)
//   ERR         one-cycle pulse when a START is rejected for bad parameters
//   ADDRA       SRAM read address (holds while ENA is high)
//   ENA         SRAM read enable, active-low
//   DOUTA       SRAM read data, valid the cycle after ENA low
//   DOUT        stream data
//   DOUT_VALID  stream data valid
//   DOUT_READY  downstream ready
//   DOUT_LAST   marks the final word of the burst
module sram_rd_streamer #(
  parameter int unsigned DEPTH = 768,
  parameter int unsigned WIDTH = 52,
  parameter int unsigned AW    = 10,
  parameter int unsigned FD    = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [AW-1:0]    BASE_ADDR,
  input  logic [AW-1:0]    LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [AW-1:0]    ADDRA,
  output logic             ENA,
  input  logic [WIDTH-1:0] DOUTA,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             DOUT_LAST
);

  localparam int unsigned PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int unsigned CW = $clog2(FD + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Control state
  state_e          state_q;
  logic            ena_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   rem_q;       // reads still to be scheduled after the current one
  logic            iss_last_q;  // read issued this cycle is the final one
  logic            done_q;
  logic            err_q;

  // Credit and return pipeline
  logic [CW-1:0]   out_q;       // reads issued in earlier cycles and not yet popped
  logic [CW-1:0]   out_d;
  logic            pend_q;      // DOUTA carries a live read this cycle
  logic            pend_last_q;

  // Output buffer
  logic [WIDTH-1:0] fifo_data_q [FD];
  logic [FD-1:0]    fifo_last_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  logic            issue;
  logic            push;
  logic            pop;
  logic            start_bad;
  logic [AW-1:0]   addr_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == FD - 1) ? '0 : p + PW'(1);
  endfunction

  assign issue     = ~ena_q;
  assign push      = pend_q;
  assign pop       = DOUT_VALID & DOUT_READY;
  assign start_bad = (32'(BASE_ADDR) >= DEPTH) || (32'(LEN) > DEPTH);
  assign addr_nxt  = (32'(addr_q) == DEPTH - 1) ? '0 : addr_q + AW'(1);

  // Occupancy seen by the next cycle's issue decision, counting this cycle's read
  // and pop. Issuing only when this is below FD keeps in-flight plus buffered <= FD.
  always_comb begin
    out_d = out_q + CW'(issue) - CW'(pop);
  end

  // Burst control FSM; all outputs it drives are registered.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= StIdle;
      ena_q      <= 1'b1;
      addr_q     <= '0;
      rem_q      <= '0;
      iss_last_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ena_q      <= 1'b1;
      iss_last_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            if (start_bad) begin
              err_q <= 1'b1;
            end else if (LEN == '0) begin
              done_q <= 1'b1;
            end else begin
              // First read goes out in the very next cycle; the buffer is empty.
              state_q    <= StRun;
              ena_q      <= 1'b0;
              addr_q     <= BASE_ADDR;
              rem_q      <= LEN - AW'(1);
              iss_last_q <= (LEN == AW'(1));
            end
          end
        end
        StRun: begin
          if (rem_q != '0) begin
            if (out_d < CW'(FD)) begin
              ena_q      <= 1'b0;
              addr_q     <= addr_nxt;
              rem_q      <= rem_q - AW'(1);
              iss_last_q <= (rem_q == AW'(1));
            end
          end else begin
            // Nothing left to schedule: the final read is on the port this cycle.
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && DOUT_LAST) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Credit counter, SRAM return pipeline and output buffer. Reset clears pend_q,
  // so data for a read issued just before reset is dropped on return.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      out_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      fifo_last_q <= '0;
      for (int i = 0; i < int'(FD); i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      out_q       <= out_d;
      pend_q      <= issue;
      pend_last_q <= issue & iss_last_q;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= DOUTA;
        fifo_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign BUSY       = (state_q != StIdle);
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign ADDRA      = addr_q;
  assign ENA        = ena_q;
  assign DOUT_VALID = (cnt_q != '0);
  assign DOUT       = fifo_data_q[rd_ptr_q];
  assign DOUT_LAST  = DOUT_VALID & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Self-checking bench for sram_rd_streamer: table of directed bursts, a reset
// mid-burst sequence and randomized bursts, all checked against a reference model
// that derives addresses and data as mem[(base+k) mod DEPTH].
module tb_sram_rd_streamer;

  localparam int DEPTH = 768;
  localparam int WIDTH = 52;
  localparam int AW    = 10;
  localparam int FD    = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW-1:0]    len_in;
  logic             busy, done, err, ena, dout_valid, dout_ready, dout_last;
  logic [AW-1:0]    addra;
  logic [WIDTH-1:0] douta;
  logic [WIDTH-1:0] dout;

  logic [WIDTH-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  sram_rd_streamer #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW),
    .FD    (FD)
  ) dut (
    .CLK        (clk),
    .RSTN       (rstn),
    .START      (start),
    .BASE_ADDR  (base_addr),
    .LEN        (len_in),
    .BUSY       (busy),
    .DONE       (done),
    .ERR        (err),
    .ADDRA      (addra),
    .ENA        (ena),
    .DOUTA      (douta),
    .DOUT       (dout),
    .DOUT_VALID (dout_valid),
    .DOUT_READY (dout_ready),
    .DOUT_LAST  (dout_last)
  );

  always #5 clk = ~clk;

  // SRAM read port: registered output, one cycle latency.
  always @(posedge clk) begin
    if (!ena) douta <= mem[addra];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c >= 8 && c < 18) ? 1'b0 : (c % 2 == 1);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // One burst: START in cycle 0, optional extra START at cycle xcyc, ready pattern
  // rmode (0 always, 1 toggle with a 10-cycle stall, 2 random).
  task automatic run_burst(input int base, input int len, input int rmode, input int exp_err,
                           input int exp_words, input int exp_done, input int xcyc,
                           input int xbase, input int xlen, input bit no_wait,
                           input bit chk_rst);
    int issued = 0, accepted = 0, done_cnt = 0, err_cnt = 0;
    int done_cyc = -1, err_cyc = -1, first_valid = -1, end_cyc = -1;
    int budget = exp_words * 6 + 60;
    bit finished = 0, prev_stall = 0, prev_last = 0;
    logic [WIDTH-1:0] prev_dout = '0;
    if (!no_wait) begin
      @(posedge clk); #1;
    end
    rstn       = 1'b1;
    start      = 1'b1;
    base_addr  = AW'(base);
    len_in     = AW'(len);
    dout_ready = rdy(rmode, 0);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("idle_busy", busy, 0);
        check("idle_ena", ena, 1);
        check("idle_valid", dout_valid, 0);
        if (chk_rst) begin
          check("rst_addra", addra, 0);
          check("rst_dout", dout, 0);
          check("rst_last", dout_last, 0);
          check("rst_done", done, 0);
          check("rst_err", err, 0);
        end
      end
      if (exp_words > 0 && cyc == 1) check("first_read_cycle", ena, 0);
      if (!ena) begin
        check("read_in_budget", issued < exp_words, 1);
        if (issued < exp_words) check("addra", addra, (base + issued) % DEPTH);
        issued++;
      end
      check("outstanding_le_fd", (issued - accepted) <= FD, 1);
      if (prev_stall) begin
        check("stall_valid", dout_valid, 1);
        check("stall_dout", dout, prev_dout);
        check("stall_last", dout_last, prev_last);
      end
      if (dout_valid && first_valid < 0) first_valid = cyc;
      if (dout_valid && dout_ready) begin
        check("word_in_budget", accepted < exp_words, 1);
        if (accepted < exp_words) begin
          check("dout", dout, mem[(base + accepted) % DEPTH]);
          check("dout_last", dout_last, accepted == exp_words - 1);
        end
        accepted++;
      end
      if (exp_words > 0 && cyc >= 1 && done_cnt == 0 && !done) check("busy_high", busy, 1);
      if (exp_words == 0) check("busy_low", busy, 0);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
      if (err) begin
        err_cnt++;
        if (err_cnt == 1) err_cyc = cyc;
      end
      prev_stall = dout_valid & ~dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
      if (end_cyc < 0 && (done || err)) end_cyc = cyc + 2;
      if (end_cyc >= 0 && cyc >= end_cyc) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc + 1 == xcyc) begin
        start     = 1'b1;
        base_addr = AW'(xbase);
        len_in    = AW'(xlen);
      end
      dout_ready = rdy(rmode, cyc + 1);
    end
    start = 1'b0;
    check("burst_finished", finished, 1);
    check("handshakes", accepted, exp_words);
    check("reads_issued", issued, exp_words);
    check("done_count", done_cnt, (exp_err != 0) ? 0 : 1);
    check("err_count", err_cnt, exp_err);
    if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
    if (exp_err != 0) check("err_cycle", err_cyc, 1);
    if (rmode == 0 && exp_words > 0) check("first_valid_cycle", first_valid, 3);
  endtask

  typedef struct {
    int base;
    int len;
    int rmode;
    int exp_err;
    int exp_words;
    int exp_done;
    int xcyc;
    int xbase;
    int xlen;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int b, l, r, m, e, w, dc, xc;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom(), 20'(i)};
    douta      = '0;
    rstn       = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    len_in     = '0;
    dout_ready = 1'b1;

    //          base  len rmode err words done xcyc xbase xlen
    vecs[0] = '{0,    8,   0,   0,  8,    11,   4,   50,   3};
    vecs[1] = '{765,  6,   0,   0,  6,    9,   -1,   0,    0};
    vecs[2] = '{10,   16,  1,   0,  16,   -1,  -1,   0,    0};
    vecs[3] = '{0,    0,   0,   0,  0,    1,   -1,   0,    0};
    vecs[4] = '{800,  4,   0,   1,  0,    -1,  -1,   0,    0};
    vecs[5] = '{700,  769, 0,   1,  0,    -1,  -1,   0,    0};
    vecs[6] = '{384,  768, 0,   0,  768,  771,  5,   800,  4};
    vecs[7] = '{767,  1,   0,   0,  1,    4,   -1,   0,    0};
    vecs[8] = '{3,    40,  2,   0,  40,   -1,   10,  0,    768};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      run_burst(vecs[i].base, vecs[i].len, vecs[i].rmode, vecs[i].exp_err, vecs[i].exp_words,
                vecs[i].exp_done, vecs[i].xcyc, vecs[i].xbase, vecs[i].xlen, 1'b0, i == 0);
    end

    // Reset in cycle 5 of a LEN=20 burst, then START in the first cycle after reset.
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(200); len_in = AW'(20); dout_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 5) rstn = 1'b0;
    end
    @(posedge clk); #1;
    run_burst(100, 2, 0, 0, 2, 5, -1, 0, 0, 1'b1, 1'b1);

    // Randomized bursts against the model.
    for (int t = 0; t < 20; t++) begin
      b = $urandom_range(0, 799);
      r = $urandom_range(0, 9);
      if (r == 0)      l = 0;
      else if (r == 1) l = $urandom_range(769, 1023);
      else             l = $urandom_range(1, 48);
      m  = $urandom_range(0, 2);
      e  = (b >= DEPTH || l > DEPTH) ? 1 : 0;
      w  = (e != 0) ? 0 : l;
      dc = -1;
      if (e == 0 && w == 0) dc = 1;
      if (m == 0 && w > 0)  dc = w + 3;
      xc = (w > 1) ? $urandom_range(1, w) : -1;
      run_burst(b, l, m, e, w, dc, xc, $urandom_range(0, 1023), $urandom_range(0, 1023),
                1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_rd_streamer.md
SRAM_RD_STREAMER -- requirements
Module: sram_rd_streamer

Interface
REQ-001 Parameter DEPTH, default 768, number of words in the attached two-port message SRAM.
REQ-002 Parameter WIDTH, default 52, data word width in bits.
REQ-003 Parameter AW, default 10, address width in bits.
REQ-004 Parameter FD, default 4, output buffer depth in words.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 CLK  input  1  clock, rising edge; same clock as the SRAM read port CLKA.
REQ-007 RSTN  input  1  synchronous active-low reset.
REQ-008 START  input  1  one-cycle request to begin a burst read.
REQ-009 BASE_ADDR  input  AW  first word address, sampled with START.
REQ-010 LEN  input  AW  number of words to read (0..DEPTH), sampled with START.
REQ-011 BUSY  output  1  burst in progress.
REQ-012 DONE  output  1  one-cycle pulse when the last word is accepted downstream.
REQ-013 ERR  output  1  one-cycle pulse when START is rejected for bad parameters.
REQ-014 ADDRA  output  AW  SRAM read address.
REQ-015 ENA  output  1  SRAM read enable, active-low.
REQ-016 DOUTA  input  WIDTH  SRAM read data, registered in the SRAM, valid one cycle after ENA low.
REQ-017 DOUT  output  WIDTH  stream data.
REQ-018 DOUT_VALID  output  1  stream data valid.
REQ-019 DOUT_READY  input  1  downstream accepts when high together with DOUT_VALID.
REQ-020 DOUT_LAST  output  1  high with the final word of the burst.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-022 IDLE->RUN SHALL occur on START with LEN>0, BASE_ADDR<DEPTH and LEN<=DEPTH; BUSY SHALL be high from the next cycle.
REQ-023 START in IDLE with LEN=0 SHALL issue no reads, leave BUSY low and pulse DONE in the next cycle.
REQ-024 START in IDLE with BASE_ADDR>=DEPTH or LEN>DEPTH SHALL be ignored, issue no reads and pulse ERR in the next cycle.
REQ-025 START while BUSY SHALL be ignored, with no ERR pulse and no change to the current burst.
REQ-026 In RUN, read i (0..LEN-1) SHALL use address (BASE_ADDR+i) mod DEPTH, so that 767 is followed by 0.
REQ-027 A read SHALL be issued (ENA low for one cycle, ADDRA valid in the same cycle) only when in-flight reads plus buffer occupancy is less than FD.
REQ-028 ADDRA SHALL hold its last value when ENA is high.
REQ-029 DOUTA SHALL be written into the FIFO in the cycle after the corresponding ENA-low cycle.
REQ-030 The FIFO SHALL be registered: data for a read issued in cycle c SHALL appear on DOUT no earlier than cycle c+2.
REQ-031 The first ENA-low cycle SHALL be the cycle after START is sampled.
REQ-032 With DOUT_READY held high, the block SHALL sustain one word per cycle after the initial latency.
REQ-033 Words SHALL leave in issue order, and DOUT, DOUT_LAST and DOUT_VALID SHALL remain stable while DOUT_VALID is high and DOUT_READY is low.
REQ-034 RUN->DRAIN SHALL occur when the LEN-th read is issued; no ENA-low cycles SHALL occur in DRAIN.
REQ-035 DRAIN->IDLE SHALL occur in the cycle the DOUT_LAST word is accepted.
REQ-036 DONE SHALL pulse in the cycle after the DOUT_LAST word is accepted, with BUSY low in that same cycle.
REQ-037 FIFO read and write in the same cycle SHALL leave occupancy unchanged.
REQ-038 The FIFO SHALL never overflow, and DOUT_VALID SHALL never be high while the FIFO is empty.
REQ-039 LEN=DEPTH SHALL read every word exactly once, wrapping as required.

Reset
REQ-040 While RSTN is low at a CLK edge, the FSM SHALL go to IDLE, with ENA=1, ADDRA=0, BUSY=0, DONE=0, ERR=0, DOUT_VALID=0, DOUT_LAST=0, DOUT=0, in-flight count=0 and FIFO empty.
REQ-041 Reset mid-burst SHALL abort the burst immediately: no DONE pulse, and SRAM data returning after reset SHALL be discarded.
REQ-042 After RSTN rises, a new START SHALL be accepted in the first cycle.

Verification
REQ-043 BASE_ADDR=0, LEN=8, DOUT_READY=1 -> ENA low cycles 1-8, ADDRA 0..7, DOUT_VALID cycles 3-10 with mem[0..7], DOUT_LAST in cycle 10, DONE in cycle 11.
REQ-044 BASE_ADDR=765, LEN=6 -> addresses 765,766,767,0,1,2 in order, DOUT_LAST on mem[2].
REQ-045 LEN=16 with DOUT_READY toggling 1/0 and a 10-cycle low stall -> at most FD reads outstanding or buffered, no lost or duplicate word, data stable during stall, and exactly 16 handshakes.
REQ-046 START with LEN=0 -> DONE in the next cycle, no ENA low, and BUSY stays 0; START with BASE_ADDR=800 -> ERR pulse and no reads.
REQ-047 RSTN low in cycle 5 of a LEN=20 burst -> all outputs at reset values in the next cycle, no DONE; a following START with BASE_ADDR=100, LEN=2 returns mem[100] and mem[101] correctly.
REQ-048 Second START during a busy burst, plus LEN=768 from BASE_ADDR=384 -> second START ignored, and all 768 words delivered once in wrapped order.
